// File: rtl/cbit_clock_sweeper.sv
// cbit_clock_sweeper: port-1 master for the cbit BRAM. Sweeps every address
// once, read-and-clears each access bit, and queues addresses whose bit was 0
// (untouched since the previous sweep) as eviction candidates on a
// valid/ready stream.
// Optional build macro CBIT_SWEEP_CONT_EN adds sweep_cont for continuous
// back-to-back sweeping.
module cbit_clock_sweeper #(
  parameter int L2_DEPTH      = 8,
  parameter int FIFO_L2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sweep_start,
`ifdef CBIT_SWEEP_CONT_EN
  input  logic                sweep_cont,
`endif
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [L2_DEPTH:0]   cand_total,
  output logic                mem_en,
  output logic [L2_DEPTH-1:0] mem_addr,
  output logic                mem_regce,
  output logic                mem_rst,
  input  logic                mem_cbit,
  output logic                cand_valid,
  input  logic                cand_ready,
  output logic [L2_DEPTH-1:0] cand_addr
);

  localparam int FDEPTH = 2**FIFO_L2_DEPTH;
  localparam int CW     = FIFO_L2_DEPTH + 2;

  localparam logic [L2_DEPTH-1:0]    ADDR_ONE = 1;
  localparam logic [L2_DEPTH:0]      TOT_ONE  = 1;
  localparam logic [FIFO_L2_DEPTH-1:0] PTR_ONE = 1;
  localparam logic [FIFO_L2_DEPTH:0] CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [L2_DEPTH-1:0]       ptr;
  logic                      clr_sweep;

  // Read pipeline: stage 1 = BRAM output register load, stage 2 = dout valid.
  logic [2:1]                      vld_pipe;
  logic [2:1][L2_DEPTH-1:0]        addr_pipe;

  // Candidate FIFO (first-word-fall-through).
  logic [L2_DEPTH-1:0]       fifo_mem [FDEPTH];
  logic [FIFO_L2_DEPTH-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_L2_DEPTH:0]    fifo_count;
  logic                      push, pop;

  // Reads in flight plus buffered candidates: every issued read may still
  // turn into a push, so it holds a FIFO slot until it resolves.
  logic [CW-1:0]             credit_used;
  logic                      credit_ok;

  assign credit_used = CW'(fifo_count) + CW'(vld_pipe[1]) + CW'(vld_pipe[2]);
  assign credit_ok   = credit_used < CW'(FDEPTH);

  assign push       = vld_pipe[2] && !mem_cbit;
  assign pop        = cand_valid && cand_ready;
  assign cand_valid = (fifo_count != '0);
  assign cand_addr  = fifo_mem[rd_ptr];

  assign sweep_busy = (state != IDLE);
  assign mem_addr   = ptr;
  assign mem_regce  = vld_pipe[1];

  // Next-state, read issue and done pulse.
  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    sweep_done = 1'b0;
    clr_sweep  = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt = SCAN;
          clr_sweep = 1'b1;
        end
      end
      SCAN: begin
        if (credit_ok) begin
          mem_en = 1'b1;
          if (ptr == '1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // FIFO contents may still be waiting; only the read pipe must be empty.
        if (vld_pipe == '0) begin
          sweep_done = 1'b1;
`ifdef CBIT_SWEEP_CONT_EN
          if (sweep_cont) begin
            state_nxt = SCAN;
            clr_sweep = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, address pointer, candidate counter and BRAM output-reset control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cand_total <= '0;
      mem_rst    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_rst <= (state == IDLE);
      if (clr_sweep)   ptr <= '0;
      else if (mem_en) ptr <= ptr + ADDR_ONE;
      // Max value 2**L2_DEPTH fits in L2_DEPTH+1 bits, so no saturation logic.
      if (clr_sweep)   cand_total <= '0;
      else if (push)   cand_total <= cand_total + TOT_ONE;
    end
  end

  // Read request valid/address shift register matching the 2-cycle BRAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= mem_en;
      vld_pipe[2]  <= vld_pipe[1];
      addr_pipe[1] <= ptr;
      addr_pipe[2] <= addr_pipe[1];
    end
  end

  // Candidate FIFO; simultaneous push and pop both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FDEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= addr_pipe[2];
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cbit_clock_sweeper.sv
// Bench for cbit_clock_sweeper: a behavioural cbit BRAM with a 2-cycle
// read-and-clear port and a port-2 "touch", plus a reference model that
// derives the expected candidate list from a snapshot of the bits.
module tb_cbit_clock_sweeper;
  localparam int L2 = 3;
  localparam int N  = 8;
  localparam int FD = 4;
  localparam logic [N-1:0] PRE = 8'b0100_1101;  // cbits {1,0,1,1,0,0,1,0}, addr 0 first

  logic clk = 1'b0, rst = 1'b1, sweep_start = 1'b0, cand_ready = 1'b0;
`ifdef CBIT_SWEEP_CONT_EN
  logic sweep_cont = 1'b0;
`endif
  logic          sweep_busy, sweep_done, mem_en, mem_regce, mem_rst, mem_cbit, cand_valid;
  logic [L2:0]   cand_total;
  logic [L2-1:0] mem_addr, cand_addr;

  int tests = 0, fails = 0;

  cbit_clock_sweeper #(.L2_DEPTH(L2), .FIFO_L2_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .sweep_start(sweep_start),
`ifdef CBIT_SWEEP_CONT_EN
    .sweep_cont(sweep_cont),
`endif
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .cand_total(cand_total),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_regce(mem_regce), .mem_rst(mem_rst),
    .mem_cbit(mem_cbit), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_addr(cand_addr)
  );

  always #5 clk = ~clk;

  // BRAM model: port 1 read-and-clear with output register, port 2 sets a bit.
  logic [N-1:0]  bits = '0;
  logic          lat = 1'b0, dout = 1'b0;
  logic          load = 1'b0, p2_en = 1'b0;
  logic [N-1:0]  load_val = '0;
  logic [L2-1:0] p2_addr = '0;
  assign mem_cbit = dout;

  // Memory array, read latch and output register of the modelled BRAM.
  always @(posedge clk) begin
    if (load) bits <= load_val;
    else begin
      if (p2_en) bits[p2_addr] <= 1'b1;
      if (mem_en) begin
        lat            <= bits[mem_addr];
        bits[mem_addr] <= 1'b0;
      end
    end
    if (mem_rst)        dout <= 1'b0;
    else if (mem_regce) dout <= lat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(sweep_busy), 0);
    check({tag, "_done"},  32'(sweep_done), 0);
    check({tag, "_total"}, 32'(cand_total), 0);
    check({tag, "_en"},    32'(mem_en),     0);
    check({tag, "_addr"},  32'(mem_addr),   0);
    check({tag, "_regce"}, 32'(mem_regce),  0);
    check({tag, "_mrst"},  32'(mem_rst),    0);
    check({tag, "_cvld"},  32'(cand_valid), 0);
    check({tag, "_caddr"}, 32'(cand_addr),  0);
  endtask

  task automatic load_bits(input logic [N-1:0] v);
    load = 1'b1; load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One full sweep from a negedge. rmode: 0 ready=1, 1 random ready,
  // 2 ready=0 for 20 cycles then 1. touch>=0 sets that bit via port 2 once
  // the sweeper has moved past it.
  task automatic run_sweep(input string tag, input int rmode, input int touch);
    int q[$];
    int nexp, got_n, dones, issues, exp_stall, zeros, cyc;
    logic prev_done, prev_stall, touched;
    logic [L2-1:0] prev_addr;
    logic [N-1:0] exp_bits;
    got_n = 0; dones = 0; issues = 0; zeros = 0; exp_stall = N;
    prev_done = 0; prev_stall = 0; touched = 0; prev_addr = '0;
    for (int a = 0; a < N; a++) if (bits[a] == 1'b0) q.push_back(a);
    nexp = q.size();
    // With nothing popped, issue stops right after the FD-th zero address.
    for (int a = 0; a < N; a++)
      if (bits[a] == 1'b0 && zeros < FD) begin
        zeros++;
        if (zeros == FD) exp_stall = a + 1;
      end
    exp_bits = '0;
    if (touch >= 0) exp_bits[touch] = 1'b1;

    sweep_start = 1'b1;
    cand_ready  = (rmode == 0);
    @(negedge clk);
    sweep_start = 1'b0;
    check({tag, "_busy_start"}, 32'(sweep_busy), 1);

    for (cyc = 0; cyc < 300; cyc++) begin
      p2_en = 1'b0;
      if (prev_done) check({tag, "_busy_after_done"}, 32'(sweep_busy), 0);
      if (prev_stall && cand_valid) check({tag, "_hold"}, 32'(cand_addr), 32'(prev_addr));
      case (rmode)
        0:       cand_ready = 1'b1;
        1:       cand_ready = 1'($urandom_range(0, 1));
        default: cand_ready = (cyc >= 20);
      endcase
      if (mem_en) begin
        check({tag, "_issue_addr"}, 32'(mem_addr), 32'(issues));
        issues++;
        if (touch >= 0 && int'(mem_addr) == touch + 1) begin
          p2_en = 1'b1; p2_addr = L2'(touch); touched = 1'b1;
        end
      end
      if (rmode == 2 && cyc == 19) check({tag, "_stall_issues"}, 32'(issues), 32'(exp_stall));
      if (cand_valid && cand_ready) begin
        if (q.size() == 0) check({tag, "_extra_cand"}, 32'(cand_addr), 32'hFFFF_FFFF);
        else               check({tag, "_cand"}, 32'(cand_addr), 32'(q.pop_front()));
        got_n++;
      end
      if (sweep_done) begin
        dones++;
        check({tag, "_total_at_done"}, 32'(cand_total), 32'(nexp));
      end
      // Start pulses while busy (including the done cycle) must be ignored.
      sweep_start = sweep_busy && ($urandom_range(0, 3) == 0);
      prev_done  = sweep_done;
      prev_stall = cand_valid && !cand_ready;
      prev_addr  = cand_addr;
      @(negedge clk);
      if (dones != 0 && !sweep_busy && q.size() == 0 && !prev_done) break;
    end
    sweep_start = 1'b0;
    p2_en       = 1'b0;
    check({tag, "_no_timeout"}, 32'(cyc < 300), 1);
    check({tag, "_dones"},      32'(dones), 1);
    check({tag, "_ncand"},      32'(got_n), 32'(nexp));
    check({tag, "_total_end"},  32'(cand_total), 32'(nexp));
    check({tag, "_cvld_end"},   32'(cand_valid), 0);
    check({tag, "_bits_end"},   32'(bits), 32'(exp_bits));
    if (touch >= 0) check({tag, "_touched"}, 32'(touched), 1);
    repeat (3) begin
      @(negedge clk);
      check({tag, "_idle_en"},   32'(mem_en), 0);
      check({tag, "_idle_done"}, 32'(sweep_done), 0);
    end
  endtask

  initial begin
    int t, k;
    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_mem_rst", 32'(mem_rst), 1);
    check("idle_busy",    32'(sweep_busy), 0);

    // 1: preload, ready=1 -> 1,4,5,7.
    load_bits(PRE);
    run_sweep("t1", 0, -1);

    // 2: ready held low; FIFO+inflight gate the issue, nothing lost.
    load_bits(PRE);
    run_sweep("t2", 2, -1);
    load_bits('0);
    run_sweep("t2z", 2, -1);

    // 3: back-to-back sweeps, second one finds all addresses.
    load_bits(PRE);
    run_sweep("t3a", 0, -1);
    run_sweep("t3b", 0, -1);

    // 5: port-2 touch of address 6 after it was swept.
    load_bits(PRE);
    run_sweep("t5a", 0, 6);
    run_sweep("t5b", 1, -1);

    // 4: reset mid-SCAN while address 3 is being issued.
    load_bits(PRE);
    cand_ready  = 1'b1;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (k = 0; k < 50; k++) begin
      if (mem_en && mem_addr == 3'd3) break;
      @(negedge clk);
    end
    check("t4_reached_addr3", 32'(k < 50), 1);
    rst = 1'b1;
    #1;
    check_all_zero("t4_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_no_en", 32'(mem_en), 0);
    end
    check("t4_bits", 32'(bits), 32'(8'b0100_1000));
    run_sweep("t4b", 0, -1);

    // Random preloads, random ready, random port-2 touches.
    repeat (6) begin
      load_bits(N'($urandom));
      t = $urandom_range(0, 7);
      run_sweep("rnd", 1, (t == 7) ? -1 : t);
    end

`ifdef CBIT_SWEEP_CONT_EN
    // 6: continuous sweeping.
    begin
      int d;
      logic dropped;
      d = 0; dropped = 1'b0;
      load_bits('0);
      cand_ready  = 1'b1;
      sweep_cont  = 1'b1;
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      repeat (60) begin
        if (!sweep_busy) dropped = 1'b1;
        if (sweep_done) d++;
        @(negedge clk);
      end
      check("t6_busy_held", 32'(dropped), 0);
      check("t6_many_dones", 32'(d >= 3), 1);
      sweep_cont = 1'b0;
      for (k = 0; k < 40 && sweep_busy; k++) @(negedge clk);
      check("t6_idle", 32'(sweep_busy), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
